// File: rtl/lcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_pkg : constants and types shared by the character-LCD driver blocks.
// Revision: 1.0
// ---------------------------------------------------------------------------
package lcd_pkg;

  localparam int unsigned TICKS_W                 = 17;
  localparam int unsigned LCD_TICK_PERIOD_DEFAULT = 50000;

  // Sequencers hold their prev_ticks register in this type.
  typedef logic [TICKS_W-1:0] tick_t;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_tick_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// lcd_tick_generator : prescaled, pausable tick counter pacing the LCD FSMs.
// Revision: 1.0
// ---------------------------------------------------------------------------
module lcd_tick_generator #(
  parameter int unsigned TICK_PERIOD = lcd_pkg::LCD_TICK_PERIOD_DEFAULT,
  parameter int unsigned TICKS_W     = lcd_pkg::TICKS_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [TICKS_W-1:0] ticks,
  output logic               tick_stb
);

  localparam int unsigned       DIV_W    = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_PERIOD - 1);

  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [TICKS_W-1:0] ticks_q,   ticks_d;
  logic               tick_stb_q, tick_stb_d;

  // Pausing clears the prescaler so a resume always waits a full period.
  always_comb begin
    div_cnt_d  = div_cnt_q;
    ticks_d    = ticks_q;
    tick_stb_d = 1'b0;
    if (!start) begin
      div_cnt_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d  = '0;
      ticks_d    = ticks_q + 1'b1;
      tick_stb_d = 1'b1;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q  <= '0;
      ticks_q    <= '0;
      tick_stb_q <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      ticks_q    <= ticks_d;
      tick_stb_q <= tick_stb_d;
    end
  end

  assign ticks    = ticks_q;
  assign tick_stb = tick_stb_q;

endmodule : lcd_tick_generator
`default_nettype wire

// File: tb/tb_lcd_tick_generator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_lcd_tick_generator : directed self-checking bench for lcd_tick_generator.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_lcd_tick_generator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start_def = 1'b0;
  logic        start_w = 1'b0;
  logic [16:0] ticks, ticks_def;
  logic [2:0]  ticks_w;
  logic        stb, stb_def, stb_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lcd_tick_generator #(.TICK_PERIOD(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ticks(ticks), .tick_stb(stb)
  );

  lcd_tick_generator u_dut_def (
    .clk(clk), .rst_n(rst_n), .start(start_def), .ticks(ticks_def), .tick_stb(stb_def)
  );

  lcd_tick_generator #(.TICK_PERIOD(2), .TICKS_W(3)) u_dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .ticks(ticks_w), .tick_stb(stb_w)
  );

  task automatic do_reset();
    start = 1'b0; start_def = 1'b0; start_w = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (ticks !== 17'd0 || stb !== 1'b0) begin
      n_fail++; $display("FAIL reset_init ticks=%0d stb=%0b want 0/0", ticks, stb);
    end
    start = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (ticks !== 17'd1) begin
      n_fail++; $display("FAIL reset_precount ticks=%0d want 1", ticks);
    end
    // Assert reset between edges; outputs must clear before the next posedge.
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (ticks !== 17'd0 || stb !== 1'b0) begin
      n_fail++; $display("FAIL reset_async ticks=%0d stb=%0b want 0/0", ticks, stb);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if (ticks !== 17'd0 || stb !== 1'b0) begin
        n_fail++; $display("FAIL reset_hold[%0d] ticks=%0d stb=%0b want 0/0", i, ticks, stb);
      end
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_period();
    do_reset();
    start = 1'b1;
    for (int e = 1; e <= 13; e++) begin
      @(negedge clk);
      n_tests++;
      if (ticks !== 17'(e / 4) || stb !== ((e % 4) == 0)) begin
        n_fail++;
        $display("FAIL period_edge%0d ticks=%0d stb=%0b want %0d/%0b",
                 e, ticks, stb, e / 4, (e % 4) == 0);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_pause();
    do_reset();
    start = 1'b1;
    repeat (6) @(negedge clk);
    n_tests++;
    if (ticks !== 17'd1) begin
      n_fail++; $display("FAIL pause_pre ticks=%0d want 1", ticks);
    end
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_tests++;
      if (ticks !== 17'd1 || stb !== 1'b0) begin
        n_fail++; $display("FAIL pause_hold[%0d] ticks=%0d stb=%0b want 1/0", i, ticks, stb);
      end
    end
    start = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge clk);
      n_tests++;
      if (ticks !== ((e == 4) ? 17'd2 : 17'd1) || stb !== (e == 4)) begin
        n_fail++;
        $display("FAIL pause_resume_edge%0d ticks=%0d stb=%0b want %0d/%0b",
                 e, ticks, stb, (e == 4) ? 2 : 1, e == 4);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_terminal_start_low();
    do_reset();
    start = 1'b1;
    repeat (3) @(negedge clk);
    // Prescaler now at its terminal count; dropping start must suppress the tick.
    start = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ticks !== 17'd0 || stb !== 1'b0) begin
      n_fail++; $display("FAIL term_start_low ticks=%0d stb=%0b want 0/0", ticks, stb);
    end
    start = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (ticks !== 17'd0) begin
      n_fail++; $display("FAIL term_resume_early ticks=%0d want 0", ticks);
    end
    @(negedge clk);
    n_tests++;
    if (ticks !== 17'd1 || stb !== 1'b1) begin
      n_fail++; $display("FAIL term_resume ticks=%0d stb=%0b want 1/1", ticks, stb);
    end
    start = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    start_w = 1'b1;
    repeat (14) @(negedge clk);
    n_tests++;
    if (ticks_w !== 3'd7 || stb_w !== 1'b1) begin
      n_fail++; $display("FAIL wrap_max ticks=%0d stb=%0b want 7/1", ticks_w, stb_w);
    end
    @(negedge clk);
    n_tests++;
    if (ticks_w !== 3'd7 || stb_w !== 1'b0) begin
      n_fail++; $display("FAIL wrap_mid ticks=%0d stb=%0b want 7/0", ticks_w, stb_w);
    end
    @(negedge clk);
    n_tests++;
    if (ticks_w !== 3'd0 || stb_w !== 1'b1) begin
      n_fail++; $display("FAIL wrap_zero ticks=%0d stb=%0b want 0/1", ticks_w, stb_w);
    end
    start_w = 1'b0;
  endtask

  task automatic test_default_period();
    do_reset();
    start_def = 1'b1;
    repeat (49999) @(negedge clk);
    n_tests++;
    if (ticks_def !== 17'd0 || stb_def !== 1'b0) begin
      n_fail++; $display("FAIL default_49999 ticks=%0d stb=%0b want 0/0", ticks_def, stb_def);
    end
    @(negedge clk);
    n_tests++;
    if (ticks_def !== 17'd1 || stb_def !== 1'b1) begin
      n_fail++; $display("FAIL default_50000 ticks=%0d stb=%0b want 1/1", ticks_def, stb_def);
    end
    @(negedge clk);
    n_tests++;
    if (ticks_def !== 17'd1 || stb_def !== 1'b0) begin
      n_fail++; $display("FAIL default_50001 ticks=%0d stb=%0b want 1/0", ticks_def, stb_def);
    end
    start_def = 1'b0;
  endtask

  task automatic test_consumer();
    logic [16:0] prev;
    int steps;
    int jumps;
    do_reset();
    prev  = ticks;
    steps = 0;
    jumps = 0;
    start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      if (ticks != prev) begin
        if (ticks != prev + 17'd1) jumps++;
        steps++;
        prev = ticks;
      end
      if (e == 39) begin
        n_tests++;
        if (steps != 9) begin
          n_fail++; $display("FAIL consumer_39 steps=%0d want 9", steps);
        end
      end
    end
    n_tests++;
    if (steps != 10) begin
      n_fail++; $display("FAIL consumer_40 steps=%0d want 10", steps);
    end
    n_tests++;
    if (jumps != 0) begin
      n_fail++; $display("FAIL consumer_jumps jumps=%0d want 0", jumps);
    end
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_period();
    test_pause();
    test_terminal_start_low();
    test_wrap();
    test_default_period();
    test_consumer();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_lcd_tick_generator
`default_nettype wire

// File: doc/lcd_tick_generator.md
Name: lcd_tick_generator

Overview:
- Timebase for the character-LCD driver FSMs (init/clean/write sequencers).
- While `start` is high, a prescaler divides `clk` and advances a 17-bit tick counter once per period.
- Consumers register the previous `ticks` value and advance one FSM step whenever `ticks` differs from it. This guarantees LCD setup/hold/execution time between E edges.
- While `start` is low, the counter freezes and the prescaler is cleared.

Parameters:
- TICK_PERIOD, 50000, clk cycles per tick (1 ms at 50 MHz; covers the LCD clear-display 1.52 ms across two FSM steps); legal range 2..2^20.
- TICKS_W, 17, width of the tick counter output.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  1 = counting enabled, 0 = paused (prescaler cleared, ticks held).
- ticks  output  TICKS_W  free-running tick count, registered.
- tick_stb  output  1  one-clk strobe, high in the cycle in which `ticks` takes its new value.

Behaviour:
- Reset (rst_n=0, asynchronous, any time):
  - prescaler = 0, ticks = 0, tick_stb = 0 immediately.
  - Release is synchronous in effect: the first count happens on the first rising edge after rst_n=1 with start=1.
- Prescaler: internal counter `div_cnt`, width ceil(log2(TICK_PERIOD)).
- Each rising edge with start=1:
  - If div_cnt == TICK_PERIOD-1: div_cnt <= 0; ticks <= ticks+1; tick_stb <= 1.
  - Otherwise: div_cnt <= div_cnt+1; tick_stb <= 0.
- Each rising edge with start=0: div_cnt <= 0; ticks holds; tick_stb <= 0.
- Latency:
  - Starting from div_cnt=0 with start held high, the first ticks increment is visible after exactly TICK_PERIOD rising edges.
  - Subsequent increments follow every TICK_PERIOD edges.
  - tick_stb and the new ticks value appear in the same cycle.
- Wrap-around: ticks is modulo 2^TICKS_W. 2^17-1 -> 0 is a normal increment with tick_stb=1, since consumers detect inequality, not magnitude.
- Pause/resume:
  - Deasserting start mid-period discards partial progress.
  - Reasserting start requires a full TICK_PERIOD edges before the next increment.
  - ticks value is retained across the pause.
- start toggled in the same cycle as the terminal count: start is sampled on that edge; start=0 on the edge means no increment.
- ticks never changes by more than 1 per TICK_PERIOD cycles, and never changes while start=0.
- No combinational path from start to outputs; all outputs are registers.

Decomposition:
- Shared package `lcd_pkg`:
  - TICKS_W = 17
  - LCD_TICK_PERIOD_DEFAULT = 50000
  - tick count typedef (logic [TICKS_W-1:0]) used by LCD sequencers for their prev_ticks registers
- No sub-module; prescaler and counter are a single module.

Test Plan:
- Reset: drive rst_n=0 mid-count with start=1, TICK_PERIOD=4 -> ticks=0 and tick_stb=0 asynchronously, before the next clk edge; remain 0 while rst_n=0.
- Period: rst_n=1, start=1 held, TICK_PERIOD=4 -> ticks goes 1,2,3 at edges 4,8,12; tick_stb high exactly at those cycles, low otherwise.
- Pause: start=1 for 6 edges (ticks=1, div_cnt=2), then start=0 for 10 edges -> ticks stays 1, no strobe. Then start=1 -> ticks=2 exactly 4 edges later.
- Wrap: force ticks to 17'h1FFFF (or run to it), start=1 -> next increment gives ticks=0 with tick_stb=1.
- Default parameter: TICK_PERIOD=50000, start=1 -> first increment at edge 50000, not 49999 or 50001.
- Consumer check: model the LCD FSM using prev_ticks != ticks -> exactly one FSM step per tick; 10 steps complete in 10*TICK_PERIOD cycles.
